// File: rtl/alu_arbiter_pkg.sv
// Shared ALU sizing, opcodes and the arbiter FSM state type.
package alu_arbiter_pkg;

   localparam int unsigned NUM_SIZE      = 16;
   localparam int unsigned CMD_SIZE_LOG2 = 2;
   localparam int unsigned CMD_W         = 2 ** CMD_SIZE_LOG2;

   localparam logic [CMD_W-1:0] NOOP = 4'h0;
   localparam logic [CMD_W-1:0] ADD  = 4'h1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_t;

   function automatic logic is_supported(input logic [CMD_W-1:0] cmd);
      return (cmd == NOOP) || (cmd == ADD);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   logic        found;
   int unsigned idx;

   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (32'(ptr) + i) % NUM_REQ;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            gnt_idx    = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU among NUM_REQ requesters (IDLE/EXEC/RESP).
// Optional per-requester grant counters: define ALU_ARB_STATS_EN.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic signed [NUM_SIZE-1:0]   req_in1 [NUM_REQ],
   input  logic signed [NUM_SIZE-1:0]   req_in2 [NUM_REQ],
   input  logic [CMD_W-1:0]             req_cmd [NUM_REQ],
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic signed [NUM_SIZE-1:0]   rsp_data,
   output logic                         rsp_err,
   output logic                         alu_reset,
   output logic                         alu_enable,
   output logic [NUM_SIZE-1:0]          alu_in1,
   output logic [NUM_SIZE-1:0]          alu_in2,
   output logic [CMD_W-1:0]             alu_cmd,
   input  logic [NUM_SIZE-1:0]          alu_out
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [NUM_REQ-1:0][15:0]     stat_grants
`endif
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [IDX_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] grant;
   logic               accept;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req     (req_valid),
      .ptr     (ptr),
      .grant   (grant),
      .gnt_idx (gnt_idx)
   );

   // Acceptance is a same-cycle pulse so that the response lands two cycles later.
   assign accept     = (state == ST_IDLE) && (|req_valid) && !reset;
   assign req_ready  = accept ? grant : '0;
   assign alu_reset  = reset;
   assign alu_enable = !reset;
   assign rsp_data   = rsp_valid ? $signed(alu_out) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_err   <= 1'b0;
         alu_cmd   <= NOOP;
         alu_in1   <= '0;
         alu_in2   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  rsp_id  <= gnt_idx;
                  alu_in1 <= req_in1[gnt_idx];
                  alu_in2 <= req_in2[gnt_idx];
                  alu_cmd <= req_cmd[gnt_idx];
                  ptr     <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                  state   <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_err   <= !is_supported(alu_cmd);
               alu_cmd   <= NOOP;
               alu_in1   <= '0;
               alu_in2   <= '0;
               rsp_valid <= 1'b1;
               state     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_grants <= '0;
      end else if (accept && (stat_grants[gnt_idx] != 16'hFFFF)) begin
         stat_grants[gnt_idx] <= stat_grants[gnt_idx] + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int unsigned NUM_REQ = 4;

   logic                       clk = 1'b0;
   logic                       reset;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic signed [NUM_SIZE-1:0] req_in1 [NUM_REQ];
   logic signed [NUM_SIZE-1:0] req_in2 [NUM_REQ];
   logic [CMD_W-1:0]           req_cmd [NUM_REQ];
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [1:0]                 rsp_id;
   logic signed [NUM_SIZE-1:0] rsp_data;
   logic                       rsp_err;
   logic                       alu_reset;
   logic                       alu_enable;
   logic [NUM_SIZE-1:0]        alu_in1;
   logic [NUM_SIZE-1:0]        alu_in2;
   logic [CMD_W-1:0]           alu_cmd;
   logic [NUM_SIZE-1:0]        alu_out;
`ifdef ALU_ARB_STATS_EN
   logic [NUM_REQ-1:0][15:0]   stat_grants;
`endif

   int checks = 0;
   int errors = 0;

   alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_in1    (req_in1),
      .req_in2    (req_in2),
      .req_cmd    (req_cmd),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .rsp_err    (rsp_err),
      .alu_reset  (alu_reset),
      .alu_enable (alu_enable),
      .alu_in1    (alu_in1),
      .alu_in2    (alu_in2),
      .alu_cmd    (alu_cmd),
      .alu_out    (alu_out)
`ifdef ALU_ARB_STATS_EN
      ,
      .stat_grants(stat_grants)
`endif
   );

   always #5 clk = ~clk;

   // ALU: ADD updates the result register, every other opcode holds it.
   always @(posedge clk) begin
      if (alu_reset)
         alu_out <= '0;
      else if (alu_enable && alu_cmd == ADD)
         alu_out <= alu_in1 + alu_in2;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_in1[i] = '0;
         req_in2[i] = '0;
         req_cmd[i] = NOOP;
      end
   endtask

   initial begin
      reset     = 1'b1;
      rsp_ready = 1'b1;
      clear_reqs();
      repeat (3) tick();
      check("rst_alu_reset", 32'(alu_reset), 32'd1);
      check("rst_alu_enable", 32'(alu_enable), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);

      reset = 1'b0;
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_alu_cmd", 32'(alu_cmd), 32'(NOOP));
      check("run_alu_enable", 32'(alu_enable), 32'd1);

      // Single ADD from requester 0: 5 + 7
      req_valid = 4'b0001; req_in1[0] = 16'sd5; req_in2[0] = 16'sd7; req_cmd[0] = ADD;
      #1;
      check("single_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = '0; #1;
      check("single_exec_ready", 32'(req_ready), 32'h0);
      check("single_alu_in1", 32'(alu_in1), 32'd5);
      check("single_alu_in2", 32'(alu_in2), 32'd7);
      check("single_alu_cmd", 32'(alu_cmd), 32'(ADD));
      check("single_exec_valid", 32'(rsp_valid), 32'd0);
      tick();
      check("single_rsp_valid", 32'(rsp_valid), 32'd1);
      check("single_rsp_data", 32'(rsp_data), 32'd12);
      check("single_rsp_id", 32'(rsp_id), 32'd0);
      check("single_rsp_err", 32'(rsp_err), 32'd0);
      check("single_resp_cmd", 32'(alu_cmd), 32'(NOOP));
      check("single_resp_in1", 32'(alu_in1), 32'd0);
      tick();
      check("single_done_valid", 32'(rsp_valid), 32'd0);

      // Negative operands from requester 2: -3 + 1
      req_valid = 4'b0100; req_in1[2] = -16'sd3; req_in2[2] = 16'sd1; req_cmd[2] = ADD;
      #1;
      check("neg_ready", 32'(req_ready), 32'h4);
      tick(); req_valid = '0;
      tick();
      check("neg_rsp_data", 32'(rsp_data), 32'hFFFF_FFFE);
      check("neg_rsp_id", 32'(rsp_id), 32'd2);
      tick();

      // Requester 3 produces 12 again, ahead of the bad-opcode request
      req_valid = 4'b1000; req_in1[3] = 16'sd5; req_in2[3] = 16'sd7; req_cmd[3] = ADD;
      #1;
      check("prior_ready", 32'(req_ready), 32'h8);
      tick(); req_valid = '0;
      tick();
      check("prior_rsp_data", 32'(rsp_data), 32'd12);
      tick();

      // Bad opcode from requester 1, held off by 5 cycles of backpressure
      req_valid = 4'b0010; req_cmd[1] = 4'hF; req_in1[1] = 16'sd100; req_in2[1] = 16'sd1;
      #1;
      check("bad_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = 4'b0001; req_cmd[0] = NOOP; rsp_ready = 1'b0;
      #1;
      check("bad_exec_ready", 32'(req_ready), 32'h0);
      tick();
      check("bad_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bad_rsp_err", 32'(rsp_err), 32'd1);
      check("bad_rsp_data", 32'(rsp_data), 32'd12);
      check("bad_rsp_id", 32'(rsp_id), 32'd1);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_data", 32'(rsp_data), 32'd12);
         check("bp_id", 32'(rsp_id), 32'd1);
         check("bp_err", 32'(rsp_err), 32'd1);
         check("bp_ready", 32'(req_ready), 32'h0);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(req_ready), 32'h0);
      tick();
      check("bp_resume_ready", 32'(req_ready), 32'h1);
      tick(); req_valid = '0;
      tick();
      check("noop_rsp_data", 32'(rsp_data), 32'd12);
      check("noop_rsp_err", 32'(rsp_err), 32'd0);
      check("noop_rsp_id", 32'(rsp_id), 32'd0);
      tick();

      // Reset while in RESP: pointer (currently 1) must return to 0
      req_valid = 4'b0010; req_cmd[1] = ADD; req_in1[1] = 16'sd2; req_in2[1] = 16'sd2;
      #1;
      check("rr_pre_ready", 32'(req_ready), 32'h2);
      tick(); req_valid = '0; rsp_ready = 1'b0;
      tick();
      check("rr_pre_rsp_valid", 32'(rsp_valid), 32'd1);
      reset = 1'b1;
      #1;
      check("rr_alu_reset", 32'(alu_reset), 32'd1);
      tick();
      reset = 1'b0; rsp_ready = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_in1[i] = 16'(i * 10);
         req_in2[i] = 16'sd1;
         req_cmd[i] = ADD;
      end
      req_valid = 4'hF;
      #1;
      check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rr_alu_cmd", 32'(alu_cmd), 32'(NOOP));

      // Fairness: all requesters held high, grants 0,1,2,3,0 every 3 cycles
      for (int k = 0; k < 5; k++) begin
         check("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
         tick();
         check("fair_exec_ready", 32'(req_ready), 32'h0);
         tick();
         check("fair_resp_ready", 32'(req_ready), 32'h0);
         check("fair_rsp_id", 32'(rsp_id), 32'(k % 4));
         check("fair_rsp_data", 32'(rsp_data), 32'((k % 4) * 10 + 1));
         tick();
      end
      req_valid = '0;

`ifdef ALU_ARB_STATS_EN
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      check("stat_reset", 32'(stat_grants[1]), 32'd0);
      req_valid = 4'b0010;
      repeat (70000 * 3 + 3) tick();
      req_valid = '0;
      check("stat_sat1", 32'(stat_grants[1]), 32'hFFFF);
      check("stat_zero0", 32'(stat_grants[0]), 32'd0);
`endif

      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
